// File: rtl/init_pop_gen.sv
// Initial population generator: seeds an xorshift32 PRNG on start and fills the
// population register one CHUNK_BITS slice per clock, then pulses done.
module init_pop_gen #(
  parameter int unsigned NUM_PATHS  = 50,
  parameter int unsigned PATH_BITS  = 150,
  parameter int unsigned CHUNK_BITS = 30
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [31:0]                    prg_seed,
  output logic [NUM_PATHS*PATH_BITS-1:0] population,
  output logic                           done,
  output logic                           busy
);

  localparam int unsigned PopBits   = NUM_PATHS * PATH_BITS;
  localparam int unsigned NumChunks = PopBits / CHUNK_BITS;
  localparam int unsigned IdxW      = $clog2(NumChunks);
  // Zero is the xorshift fixed point, so a zero seed is replaced.
  localparam logic [31:0] SeedFallback = 32'h2545F491;

  typedef enum logic [0:0] {StIdle, StGen} state_e;

  state_e              state_q, state_d;
  logic [31:0]         prng_q;
  logic [31:0]         nx;
  logic [IdxW-1:0]     idx_q;
  logic                last_chunk;
  logic [PopBits-1:0]  pop_q;
  logic                done_q;

  function automatic logic [31:0] xorshift32(input logic [31:0] v);
    logic [31:0] x;
    x = v;
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  always_comb begin
    nx         = xorshift32(prng_q);
    last_chunk = (idx_q == IdxW'(NumChunks - 1));
    state_d    = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StGen;
      StGen:   if (last_chunk) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prng_q <= '0;
      idx_q  <= '0;
      pop_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == StIdle && start) begin
        prng_q <= (prg_seed == 32'd0) ? SeedFallback : prg_seed;
        idx_q  <= '0;
        pop_q  <= '0;
      end else if (state_q == StGen) begin
        prng_q <= nx;
        pop_q[int'(idx_q) * CHUNK_BITS +: CHUNK_BITS] <= nx[CHUNK_BITS-1:0];
        idx_q  <= idx_q + IdxW'(1);
        done_q <= last_chunk;
      end
    end
  end

  assign population = pop_q;
  assign done       = done_q;
  assign busy       = (state_q == StGen);

endmodule

// File: tb/tb_init_pop_gen.sv
// Randomized self-checking bench for init_pop_gen against a population model.
module tb_init_pop_gen;

  localparam int NP = 50;
  localparam int PB = 150;
  localparam int CB = 30;
  localparam int NC = NP * PB / CB;

  logic             clk;
  logic             rst;
  logic             start;
  logic [31:0]      prg_seed;
  logic [NP*PB-1:0] population;
  logic             done;
  logic             busy;

  int tests_run;
  int tests_failed;

  init_pop_gen #(
    .NUM_PATHS (NP),
    .PATH_BITS (PB),
    .CHUNK_BITS(CB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prg_seed  (prg_seed),
    .population(population),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: walk the generator sequence and lay 30-bit chunks end to end.
  function automatic logic [NP*PB-1:0] model_pop(input logic [31:0] seed);
    logic [NP*PB-1:0] p;
    logic [31:0]      x;
    p = '0;
    x = (seed == 32'd0) ? 32'h2545F491 : seed;
    for (int c = 0; c < NC; c++) begin
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      p[c*CB +: CB] = x[CB-1:0];
    end
    return p;
  endfunction

  task automatic compare_pop(input string tag, input logic [NP*PB-1:0] exp);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("%s_path%0d", tag, p), {10'b0, population[p*PB +: PB]},
            {10'b0, exp[p*PB +: PB]});
    end
  endtask

  // Called at a negedge: drive start, then step past the accepting edge.
  task automatic start_run(input logic [31:0] seed, input string tag);
    start    = 1'b1;
    prg_seed = seed;
    @(negedge clk);
    start    = 1'b0;
    prg_seed = $urandom;
    check({tag, "_e0_busy"}, 160'(busy), 160'd1);
    check({tag, "_e0_done"}, 160'(done), 160'd0);
    check({tag, "_e0_popzero"}, 160'(|population), 160'd0);
  endtask

  // Returns at the negedge where done is high. restart_at >= 0 pulses start mid-run.
  task automatic wait_done(input string tag, input int restart_at);
    int cycles;
    int busy_cycles;
    int done_seen;
    cycles      = 0;
    busy_cycles = 0;
    done_seen   = 0;
    while (cycles < 300 && done_seen == 0) begin
      @(negedge clk);
      start = 1'b0;
      cycles++;
      if (done) done_seen = 1;
      else if (busy) busy_cycles++;
      if (cycles == restart_at) begin
        start    = 1'b1;
        prg_seed = $urandom;
      end
    end
    check({tag, "_done_cycle"}, 160'(cycles), 160'(NC));
    check({tag, "_busy_cycles"}, 160'(busy_cycles), 160'(NC - 1));
    check({tag, "_busy_at_done"}, 160'(busy), 160'd0);
  endtask

  task automatic idle_after(input string tag, input logic [NP*PB-1:0] exp);
    repeat (3) @(negedge clk);
    check({tag, "_done_clear"}, 160'(done), 160'd0);
    check({tag, "_idle_busy"}, 160'(busy), 160'd0);
    compare_pop({tag, "_stable"}, exp);
  endtask

  initial begin
    logic [31:0] s;
    tests_run    = 0;
    tests_failed = 0;
    rst      = 1'b1;
    start    = 1'b0;
    prg_seed = 32'd0;
    #12;
    check("rst_pop", 160'(|population), 160'd0);
    check("rst_done", 160'(done), 160'd0);
    check("rst_busy", 160'(busy), 160'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_pop", 160'(|population), 160'd0);
    check("idle_done", 160'(done), 160'd0);
    check("idle_busy", 160'(busy), 160'd0);

    // Seed 1: known first chunks.
    start_run(32'd1, "s1");
    wait_done("s1", -1);
    check("s1_chunk0", 160'(population[29:0]), 160'h0042021);
    check("s1_chunk1", 160'(population[59:30]), 160'h04080601);
    compare_pop("s1", model_pop(32'd1));
    idle_after("s1", model_pop(32'd1));

    // Zero seed behaves as the fallback seed.
    @(negedge clk);
    start_run(32'd0, "s0");
    wait_done("s0", -1);
    compare_pop("s0", model_pop(32'h2545F491));
    check("s0_nonzero", 160'(|population), 160'd1);
    idle_after("s0", model_pop(32'h2545F491));

    // Restart request mid-run is ignored.
    s = $urandom;
    @(negedge clk);
    start_run(s, "rs");
    wait_done("rs", 100);
    compare_pop("rs", model_pop(s));
    idle_after("rs", model_pop(s));

    // Asynchronous reset mid-run, then a fresh run.
    s = $urandom;
    @(negedge clk);
    start_run(s, "ra");
    repeat (119) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("ra_pop", 160'(|population), 160'd0);
    check("ra_done", 160'(done), 160'd0);
    check("ra_busy", 160'(busy), 160'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_run(32'h12345678, "rb");
    wait_done("rb", -1);
    compare_pop("rb", model_pop(32'h12345678));

    // Back-to-back: start during the done cycle.
    s = $urandom;
    start_run(s, "bb");
    wait_done("bb", -1);
    compare_pop("bb", model_pop(s));
    idle_after("bb", model_pop(s));

    // Random seeds.
    for (int r = 0; r < 3; r++) begin
      s = $urandom;
      @(negedge clk);
      start_run(s, $sformatf("rnd%0d", r));
      wait_done($sformatf("rnd%0d", r), -1);
      compare_pop($sformatf("rnd%0d", r), model_pop(s));
    end
    idle_after("rndend", model_pop(s));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
